rotation_commit: RTL and testbench

Sequential stage directly downstream of the combinational rotation table. On a rotate request it latches the active piece, drives the table's inputs, captures the candidate coordinates, checks all four candidate cells against board bounds and the board occupancy RAM, and either commits the rotated piece with its new orientation or rejects it. It sits between the keypress/game-control FSM and the active-piece registers.

---
 rtl/rotation_commit_if.sv | 31 +++
 rtl/rotation_commit.sv | 137 +++++++++++++
 tb/tb_rotation_commit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotation_commit_if.sv
// rotation_commit_if: piece colour/orientation types and the signal bundle shared by
// the rotate-commit stage, the rotation table, the board RAM and the game-control FSM.
package rotation_pkg;
    typedef enum logic [2:0] {CYAN, YELLOW, PURPLE, GREEN, RED, BLUE, ORANGE} block_color;
    typedef enum logic [1:0] {NORMAL, ROT_LEFT, ROT2, ROT_RIGHT} orientation;
endpackage

interface rotation_commit_if;
    import rotation_pkg::*;
    logic rot_l_req, rot_r_req;
    block_color block, tbl_block;
    orientation cur_orientation, tbl_orientation, new_orientation;
    logic [19:0] x_block, y_block, tbl_xblock, tbl_yblock;
    logic [19:0] tbl_rot_xblock, tbl_rot_yblock, new_xblock, new_yblock;
    logic tbl_rotate_left, query_valid, occupied, busy, done, accepted;
    logic [4:0] query_x, query_y;
    modport slave (
        input rot_l_req, rot_r_req, block, x_block, y_block, cur_orientation,
              tbl_rot_xblock, tbl_rot_yblock, occupied,
        output tbl_block, tbl_rotate_left, tbl_orientation, tbl_xblock, tbl_yblock,
               query_valid, query_x, query_y, busy, done, accepted,
               new_xblock, new_yblock, new_orientation
    );
    modport master (
        output rot_l_req, rot_r_req, block, x_block, y_block, cur_orientation,
               tbl_rot_xblock, tbl_rot_yblock, occupied,
        input tbl_block, tbl_rotate_left, tbl_orientation, tbl_xblock, tbl_yblock,
              query_valid, query_x, query_y, busy, done, accepted,
              new_xblock, new_yblock, new_orientation
    );
endinterface

// File: rtl/rotation_commit.sv
// rotation_commit: latches a rotate request, checks the table's candidate cells against bounds
// and board occupancy, then commits or rejects. Define ROT_WALL_KICK_EN for x+1 / x-1 kick retries.
module rotation_commit
    import rotation_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input logic Clk,
    input logic Reset_n,
    rotation_commit_if.slave rc
);
    typedef enum logic [2:0] {IDLE, LATCH, CHECK, WAIT,
`ifdef ROT_WALL_KICK_EN
        KICK,
`endif
        FINISH} state_t;
    localparam logic [4:0] W = 5'(BOARD_W);
    localparam logic [4:0] H = 5'(BOARD_H);
    state_t state, next;
    logic [1:0] k;
    logic fail, q_prev, in_bounds, fail_now, start;
    logic [4:0] off, cx, cy;
    logic [3:0][4:0] cand_x, cand_y, cand_xo;
    orientation rot_o;
`ifdef ROT_WALL_KICK_EN
    logic [1:0] attempt;
    logic last;
    assign last = attempt == 2'd2;
`endif
    assign start = rc.rot_l_req ^ rc.rot_r_req;
    always_comb begin
        for (int i = 0; i < 4; i++) cand_xo[i] = cand_x[i] + off;
    end
    assign cx = cand_xo[k];
    assign cy = cand_y[k];
    // 5-bit unsigned compare: a wrapped -1 (31) fails the bound naturally
    assign in_bounds = cx < W && cy < H;
    assign fail_now = fail || (q_prev && rc.occupied);
    assign rot_o = rc.tbl_rotate_left ? orientation'(rc.tbl_orientation + 2'd1)
                                      : orientation'(rc.tbl_orientation - 2'd1);
    assign rc.busy = state != IDLE;
    assign rc.done = state == FINISH;
    assign rc.query_valid = state == CHECK && in_bounds;
    assign rc.query_x = rc.query_valid ? cx : 5'd0;
    assign rc.query_y = rc.query_valid ? cy : 5'd0;
    always_comb begin
        next = state;
        case (state)
            IDLE:   next = start ? LATCH : IDLE;
            LATCH:  next = rc.tbl_block == YELLOW ? FINISH : CHECK;
            CHECK:  next = k == 2'd3 ? WAIT : CHECK;
`ifdef ROT_WALL_KICK_EN
            WAIT:   next = fail_now && !last ? KICK : FINISH;
            KICK:   next = CHECK;
`else
            WAIT:   next = FINISH;
`endif
            FINISH: next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rc.tbl_block <= block_color'(3'd0);
            rc.tbl_rotate_left <= 1'b0;
            rc.tbl_orientation <= orientation'(2'd0);
            rc.tbl_xblock <= '0;
            rc.tbl_yblock <= '0;
            rc.accepted <= 1'b0;
            rc.new_xblock <= '0;
            rc.new_yblock <= '0;
            rc.new_orientation <= NORMAL;
            cand_x <= '0;
            cand_y <= '0;
            off <= '0;
            k <= '0;
            fail <= 1'b0;
            q_prev <= 1'b0;
`ifdef ROT_WALL_KICK_EN
            attempt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    rc.tbl_block <= rc.block;
                    rc.tbl_rotate_left <= rc.rot_l_req;
                    rc.tbl_orientation <= rc.cur_orientation;
                    rc.tbl_xblock <= rc.x_block;
                    rc.tbl_yblock <= rc.y_block;
                end
                LATCH: begin
                    cand_x <= rc.tbl_rot_xblock;
                    cand_y <= rc.tbl_rot_yblock;
                    off <= '0;
                    k <= '0;
                    fail <= 1'b0;
                    q_prev <= 1'b0;
`ifdef ROT_WALL_KICK_EN
                    attempt <= '0;
`endif
                    if (rc.tbl_block == YELLOW) begin
                        rc.accepted <= 1'b1;
                        rc.new_xblock <= rc.tbl_xblock;
                        rc.new_yblock <= rc.tbl_yblock;
                        rc.new_orientation <= rc.tbl_orientation;
                    end
                end
                CHECK: begin
                    k <= k + 2'd1;
                    fail <= fail_now || !in_bounds;
                    q_prev <= in_bounds;
                end
                WAIT: if (next == FINISH) begin
                    rc.accepted <= !fail_now;
                    rc.new_xblock <= fail_now ? rc.tbl_xblock : cand_xo;
                    rc.new_yblock <= fail_now ? rc.tbl_yblock : cand_y;
                    rc.new_orientation <= fail_now ? rc.tbl_orientation : rot_o;
                end
`ifdef ROT_WALL_KICK_EN
                KICK: begin
                    k <= '0;
                    fail <= 1'b0;
                    q_prev <= 1'b0;
                    attempt <= attempt + 2'd1;
                    off <= attempt == 2'd0 ? 5'd1 : 5'h1f;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rotation_commit.sv
// tb_rotation_commit: directed vector table, hand sequences for busy/reset corners, and
// randomized rotations checked against a cell-level reference model of the commit rules.
module tb_rotation_commit;
    import rotation_pkg::*;
    localparam int W = 10;
    localparam int H = 20;
`ifdef ROT_WALL_KICK_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    rotation_commit_if rc();
    rotation_commit #(.BOARD_W(W), .BOARD_H(H)) dut (.Clk(Clk), .Reset_n(Reset_n), .rc(rc));
    always #5 Clk = ~Clk;
    logic occ [32][32];
    int vectors = 0;
    int miscompares = 0;

    // rotation table stand-in: rotate every cell about cell 1 (screen coords, y down)
    function automatic logic [39:0] rot_table(input logic [19:0] xs, input logic [19:0] ys, input logic left);
        logic [19:0] rx, ry;
        int px, py, dx, dy;
        px = int'(xs[9:5]);
        py = int'(ys[9:5]);
        for (int i = 0; i < 4; i++) begin
            dx = int'(xs[5*i +: 5]) - px;
            dy = int'(ys[5*i +: 5]) - py;
            rx[5*i +: 5] = 5'((left ? px + dy : px - dy) & 31);
            ry[5*i +: 5] = 5'((left ? py - dx : py + dx) & 31);
        end
        return {rx, ry};
    endfunction

    assign {rc.tbl_rot_xblock, rc.tbl_rot_yblock} = rot_table(rc.tbl_xblock, rc.tbl_yblock, rc.tbl_rotate_left);
    always @(posedge Clk) rc.occupied <= rc.query_valid && occ[rc.query_x][rc.query_y];

    function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic void model(input block_color b, input logic [19:0] xs, input logic [19:0] ys,
                                  input orientation o, input logic left, output logic acc,
                                  output logic [19:0] nx, output logic [19:0] ny,
                                  output orientation no, output int cyc);
        logic [39:0] c;
        int offs [3];
        logic ok;
        logic [19:0] tx;
        int px, py;
        offs = '{0, 1, -1};
        c = rot_table(xs, ys, left);
        acc = b == YELLOW;
        nx = xs;
        ny = ys;
        no = o;
        cyc = b == YELLOW ? 2 : 7 + 6 * (TRIES - 1);
        for (int t = 0; t < TRIES; t++) if (!acc) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                px = (int'(c[20 + 5*i +: 5]) + offs[t]) & 31;
                py = int'(c[5*i +: 5]);
                tx[5*i +: 5] = 5'(px);
                if (px >= W || py >= H || occ[px][py]) ok = 1'b0;
            end
            if (ok) begin
                acc = 1'b1;
                nx = tx;
                ny = c[19:0];
                no = orientation'(o + (left ? 2'd1 : 2'd3));
                cyc = 7 + 6 * t;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_occ();
        for (int x = 0; x < 32; x++) for (int y = 0; y < 32; y++) occ[x][y] = 1'b0;
    endtask

    // called at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic run_op(input block_color b, input logic [19:0] xs, input logic [19:0] ys,
                          input orientation o, input logic left, output int cyc, output int nq, output int bad);
        rc.block = b;
        rc.x_block = xs;
        rc.y_block = ys;
        rc.cur_orientation = o;
        rc.rot_l_req = left;
        rc.rot_r_req = !left;
        @(posedge Clk);
        @(negedge Clk);
        rc.rot_l_req = 1'b0;
        rc.rot_r_req = 1'b0;
        cyc = -1;
        nq = 0;
        bad = 0;
        for (int c = 1; c <= 40 && cyc < 0; c++) begin
            if (!rc.busy) bad++;
            if (rc.query_valid) begin
                nq++;
                if (int'(rc.query_x) >= W || int'(rc.query_y) >= H) bad++;
            end
            if (rc.done) cyc = c;
            else @(negedge Clk);
        end
    endtask

    task automatic compare(input string name, input int cyc, input int ecyc, input logic acc,
                           input logic [19:0] nx, input logic [19:0] ny, input orientation no);
        chk({name, ".cycle"}, cyc, ecyc);
        chk({name, ".accepted"}, int'(rc.accepted), int'(acc));
        chk({name, ".new_x"}, int'(rc.new_xblock), int'(nx));
        chk({name, ".new_y"}, int'(rc.new_yblock), int'(ny));
        chk({name, ".new_orient"}, int'(rc.new_orientation), int'(no));
    endtask

    typedef struct {
        string name;
        block_color b;
        logic [19:0] xs, ys;
        orientation o;
        logic left;
        int ox, oy;
        logic acc;
        logic [19:0] nx, ny;
        orientation no;
        int cyc;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, nq, bad, seen, ndone;
        orientation o_at;
        logic acc;
        logic [19:0] nx, ny;
        orientation no;
        int ecyc;
        vecs[0] = '{"cyan_r", CYAN, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 1'b0, -1, -1,
                    1'b1, p4(4,4,4,4), p4(4,5,6,7), ROT_RIGHT, 7};
`ifdef ROT_WALL_KICK_EN
        vecs[1] = '{"cyan_blocked", CYAN, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 1'b0, 4, 7,
                    1'b1, p4(5,5,5,5), p4(4,5,6,7), ROT_RIGHT, 13};
        vecs[2] = '{"cyan_wall", CYAN, p4(0,0,0,0), p4(4,5,6,7), ROT_RIGHT, 1'b0, -1, -1,
                    1'b0, p4(0,0,0,0), p4(4,5,6,7), ROT_RIGHT, 19};
        vecs[5] = '{"cyan_floor", CYAN, p4(3,4,5,6), p4(19,19,19,19), NORMAL, 1'b0, -1, -1,
                    1'b0, p4(3,4,5,6), p4(19,19,19,19), NORMAL, 19};
`else
        vecs[1] = '{"cyan_blocked", CYAN, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 1'b0, 4, 7,
                    1'b0, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 7};
        vecs[2] = '{"cyan_wall", CYAN, p4(0,0,0,0), p4(4,5,6,7), ROT_RIGHT, 1'b0, -1, -1,
                    1'b0, p4(0,0,0,0), p4(4,5,6,7), ROT_RIGHT, 7};
        vecs[5] = '{"cyan_floor", CYAN, p4(3,4,5,6), p4(19,19,19,19), NORMAL, 1'b0, -1, -1,
                    1'b0, p4(3,4,5,6), p4(19,19,19,19), NORMAL, 7};
`endif
        vecs[3] = '{"yellow_l", YELLOW, p4(4,5,4,5), p4(0,0,1,1), NORMAL, 1'b1, -1, -1,
                    1'b1, p4(4,5,4,5), p4(0,0,1,1), NORMAL, 2};
        vecs[4] = '{"cyan_l", CYAN, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 1'b1, -1, -1,
                    1'b1, p4(4,4,4,4), p4(6,5,4,3), ROT_LEFT, 7};
        vecs[6] = '{"orient_wrap", CYAN, p4(4,4,4,4), p4(4,5,6,7), ROT_RIGHT, 1'b1, -1, -1,
                    1'b1, p4(3,4,5,6), p4(5,5,5,5), NORMAL, 7};

        rc.rot_l_req = 1'b0;
        rc.rot_r_req = 1'b0;
        rc.block = CYAN;
        rc.x_block = '0;
        rc.y_block = '0;
        rc.cur_orientation = NORMAL;
        clear_occ();
        repeat (3) @(negedge Clk);
        chk("reset_outputs", int'(|{rc.busy, rc.done, rc.accepted, rc.query_valid, rc.query_x, rc.query_y,
                                   rc.tbl_block, rc.tbl_rotate_left, rc.tbl_orientation, rc.tbl_xblock,
                                   rc.tbl_yblock, rc.new_xblock, rc.new_yblock, rc.new_orientation}), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        foreach (vecs[i]) begin
            clear_occ();
            if (vecs[i].ox >= 0) occ[vecs[i].ox][vecs[i].oy] = 1'b1;
            run_op(vecs[i].b, vecs[i].xs, vecs[i].ys, vecs[i].o, vecs[i].left, cyc, nq, bad);
            compare(vecs[i].name, cyc, vecs[i].cyc, vecs[i].acc, vecs[i].nx, vecs[i].ny, vecs[i].no);
            chk({vecs[i].name, ".busy_or_oob_query"}, bad, 0);
            if (vecs[i].b == YELLOW) chk({vecs[i].name, ".queries"}, nq, 0);
            @(negedge Clk);
        end

        // both requests together are ignored
        clear_occ();
        rc.rot_l_req = 1'b1;
        rc.rot_r_req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rc.rot_l_req = 1'b0;
        rc.rot_r_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            seen += int'(rc.busy) + int'(rc.done);
            @(negedge Clk);
        end
        chk("both_req_ignored", seen, 0);

        // a second request while busy is dropped
        rc.block = CYAN;
        rc.x_block = p4(3,4,5,6);
        rc.y_block = p4(5,5,5,5);
        rc.cur_orientation = NORMAL;
        rc.rot_r_req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rc.rot_r_req = 1'b0;
        ndone = 0;
        o_at = NORMAL;
        for (int c = 1; c <= 25; c++) begin
            rc.rot_l_req = c == 3;
            if (rc.done) begin
                ndone++;
                o_at = rc.new_orientation;
            end
            @(negedge Clk);
        end
        rc.rot_l_req = 1'b0;
        chk("busy_req.done_count", ndone, 1);
        chk("busy_req.orient", int'(o_at), int'(ROT_RIGHT));

        // reset in the middle of an operation
        rc.rot_r_req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rc.rot_r_req = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", int'(|{rc.busy, rc.done, rc.accepted, rc.query_valid, rc.query_x, rc.query_y,
                                       rc.tbl_block, rc.tbl_rotate_left, rc.tbl_orientation, rc.tbl_xblock,
                                       rc.tbl_yblock, rc.new_xblock, rc.new_yblock, rc.new_orientation}), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            ndone += int'(rc.done) + int'(rc.busy);
            @(negedge Clk);
        end
        chk("mid_reset_no_done", ndone, 0);

        for (int n = 0; n < 60; n++) begin
            int px, py;
            logic [19:0] xs, ys;
            block_color b;
            orientation o;
            logic left;
            px = int'($urandom_range(10));
            py = int'($urandom_range(20));
            for (int i = 0; i < 4; i++) begin
                xs[5*i +: 5] = 5'((i == 1 ? px : px + int'($urandom_range(4)) - 2) & 31);
                ys[5*i +: 5] = 5'((i == 1 ? py : py + int'($urandom_range(4)) - 2) & 31);
            end
            b = $urandom_range(7) == 0 ? YELLOW : block_color'($urandom_range(6));
            o = orientation'($urandom_range(3));
            left = 1'($urandom_range(1));
            clear_occ();
            for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) occ[x][y] = $urandom_range(5) == 0;
            model(b, xs, ys, o, left, acc, nx, ny, no, ecyc);
            run_op(b, xs, ys, o, left, cyc, nq, bad);
            compare($sformatf("rand%0d", n), cyc, ecyc, acc, nx, ny, no);
            chk($sformatf("rand%0d.busy_or_oob_query", n), bad, 0);
            if (b == YELLOW) chk($sformatf("rand%0d.queries", n), nq, 0);
            @(negedge Clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
